// File: rtl/draw_write_arbiter.sv
// rtl/draw_write_arbiter.sv - draw-source write bus arbiter feeding the framebuffer write port (optional clear: DRAW_WRITE_ARBITER_CLEAR_EN)
module draw_write_arbiter #(
    parameter int                     SOURCE_COUNT = 4,
    parameter int                     SEL_W        = 2,
    parameter int                     COLOR_DEPTH  = 9,
    parameter int                     FB_WIDTH     = 640,
    parameter int                     FB_HEIGHT    = 480,
    parameter int                     FB_ADDR_W    = 19,
    parameter int                     WAIT_TIMEOUT = 1024,
    parameter logic [COLOR_DEPTH-1:0] BG_COLOR     = '0
) (
    input  logic                   clk,
    input  logic                   resetN,
    input  logic                   frame,
    output logic [SEL_W-1:0]       write_source_sel,
    output logic                   write_awaited,
    input  logic                   write_active,
    input  logic [COLOR_DEPTH-1:0] write_color_data,
    input  logic                   write_transparent,
    input  logic [31:0]            write_x_addr,
    input  logic [31:0]            write_y_addr,
    output logic                   fb_we,
    output logic [FB_ADDR_W-1:0]   fb_addr,
    output logic [COLOR_DEPTH-1:0] fb_data,
    output logic                   busy,
    output logic                   frame_done,
    output logic                   frame_overrun,
    output logic                   source_timeout
);

    localparam int CNT_W = (WAIT_TIMEOUT > 1) ? $clog2(WAIT_TIMEOUT) : 1;
    localparam logic [CNT_W-1:0]     CNT_LAST = CNT_W'(WAIT_TIMEOUT - 1);
    localparam logic [SEL_W-1:0]     SEL_LAST = SEL_W'(SOURCE_COUNT - 1);
    localparam logic [FB_ADDR_W-1:0] FB_W_A   = FB_ADDR_W'(FB_WIDTH);

    typedef enum logic [2:0] {
        S_IDLE, S_CLEAR, S_GRANT, S_WAIT, S_STREAM, S_NEXT, S_DONE
    } state_t;

    state_t                 state_q, state_d;
    logic [SEL_W-1:0]       sel_q, sel_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic                   we_q, we_d;
    logic [FB_ADDR_W-1:0]   addr_q, addr_d;
    logic [COLOR_DEPTH-1:0] data_q, data_d;
    logic                   overrun_q, overrun_d;
    logic                   timeout_q, timeout_d;
    logic                   take_pixel;
    logic                   pix_ok;
    logic [FB_ADDR_W-1:0]   pix_addr;
`ifdef DRAW_WRITE_ARBITER_CLEAR_EN
    localparam logic [FB_ADDR_W-1:0] CLR_LAST = FB_ADDR_W'(FB_WIDTH * FB_HEIGHT - 1);
    logic [FB_ADDR_W-1:0]   clr_q, clr_d;
`endif

    // Pixel acceptance: sign bit clear rejects negatives, then bound against the screen
    always_comb begin
        pix_ok   = !write_transparent
                   && !write_x_addr[31] && (write_x_addr < 32'(FB_WIDTH))
                   && !write_y_addr[31] && (write_y_addr < 32'(FB_HEIGHT));
        pix_addr = write_y_addr[FB_ADDR_W-1:0] * FB_W_A + write_x_addr[FB_ADDR_W-1:0];
    end

    // Next-state, grant sequencing and write-port staging
    always_comb begin
        state_d    = state_q;
        sel_d      = sel_q;
        cnt_d      = cnt_q;
        we_d       = 1'b0;
        addr_d     = addr_q;
        data_d     = BG_COLOR;
        overrun_d  = overrun_q | (frame && (state_q != S_IDLE));
        timeout_d  = timeout_q;
        take_pixel = 1'b0;
`ifdef DRAW_WRITE_ARBITER_CLEAR_EN
        clr_d      = clr_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (frame) begin
                    sel_d = '0;
`ifdef DRAW_WRITE_ARBITER_CLEAR_EN
                    clr_d   = '0;
                    state_d = S_CLEAR;
`else
                    state_d = S_GRANT;
`endif
                end
            end
            S_CLEAR: begin
`ifdef DRAW_WRITE_ARBITER_CLEAR_EN
                we_d   = 1'b1;
                addr_d = clr_q;
                data_d = BG_COLOR;
                if (clr_q == CLR_LAST) begin
                    state_d = S_GRANT;
                end else begin
                    clr_d = clr_q + FB_ADDR_W'(1);
                end
`else
                state_d = S_IDLE;
`endif
            end
            S_GRANT: begin
                cnt_d   = '0;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (write_active) begin
                    take_pixel = 1'b1;
                    state_d    = S_STREAM;
                end else if (cnt_q == CNT_LAST) begin
                    timeout_d = 1'b1;
                    state_d   = S_NEXT;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_STREAM: begin
                if (write_active) begin
                    take_pixel = 1'b1;
                end else begin
                    state_d = S_NEXT;
                end
            end
            S_NEXT: begin
                if (sel_q == SEL_LAST) begin
                    sel_d   = '0;
                    state_d = S_DONE;
                end else begin
                    sel_d   = sel_q + SEL_W'(1);
                    state_d = S_GRANT;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        if (take_pixel && pix_ok) begin
            we_d   = 1'b1;
            addr_d = pix_addr;
            data_d = write_color_data;
        end
    end

    // State and output registers; reset also flushes the pending write
    always_ff @(posedge clk) begin
        if (!resetN) begin
            state_q   <= S_IDLE;
            sel_q     <= '0;
            cnt_q     <= '0;
            we_q      <= 1'b0;
            addr_q    <= '0;
            data_q    <= '0;
            overrun_q <= 1'b0;
            timeout_q <= 1'b0;
`ifdef DRAW_WRITE_ARBITER_CLEAR_EN
            clr_q     <= '0;
`endif
        end else begin
            state_q   <= state_d;
            sel_q     <= sel_d;
            cnt_q     <= cnt_d;
            we_q      <= we_d;
            addr_q    <= addr_d;
            data_q    <= data_d;
            overrun_q <= overrun_d;
            timeout_q <= timeout_d;
`ifdef DRAW_WRITE_ARBITER_CLEAR_EN
            clr_q     <= clr_d;
`endif
        end
    end

    assign write_source_sel = sel_q;
    assign write_awaited    = (state_q == S_WAIT);
    assign busy             = (state_q == S_CLEAR) || (state_q == S_GRANT) || (state_q == S_WAIT)
                              || (state_q == S_STREAM) || (state_q == S_NEXT);
    assign frame_done       = (state_q == S_DONE);
    assign fb_we            = we_q;
    assign fb_addr          = addr_q;
    assign fb_data          = data_q;
    assign frame_overrun    = overrun_q;
    assign source_timeout   = timeout_q;

endmodule

// File: tb/tb_draw_write_arbiter.sv
// tb/tb_draw_write_arbiter.sv - directed-vector bench for draw_write_arbiter
module tb_draw_write_arbiter;

    logic        clk = 1'b0;
    logic        resetN;
    logic        frame;
    logic [0:0]  write_source_sel;
    logic        write_awaited;
    logic        write_active;
    logic [8:0]  write_color_data;
    logic        write_transparent;
    logic [31:0] write_x_addr;
    logic [31:0] write_y_addr;
    logic        fb_we;
    logic [18:0] fb_addr;
    logic [8:0]  fb_data;
    logic        busy;
    logic        frame_done;
    logic        frame_overrun;
    logic        source_timeout;

    int n_checks = 0;
    int n_pass   = 0;

    draw_write_arbiter #(
        .SOURCE_COUNT(2), .SEL_W(1), .COLOR_DEPTH(9), .FB_WIDTH(640),
        .FB_HEIGHT(480), .FB_ADDR_W(19), .WAIT_TIMEOUT(16), .BG_COLOR(9'h000)
    ) dut (
        .clk(clk), .resetN(resetN), .frame(frame),
        .write_source_sel(write_source_sel), .write_awaited(write_awaited),
        .write_active(write_active), .write_color_data(write_color_data),
        .write_transparent(write_transparent), .write_x_addr(write_x_addr),
        .write_y_addr(write_y_addr), .fb_we(fb_we), .fb_addr(fb_addr),
        .fb_data(fb_data), .busy(busy), .frame_done(frame_done),
        .frame_overrun(frame_overrun), .source_timeout(source_timeout)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_frame();
        frame = 1'b1;
        tick();
        frame = 1'b0;
    endtask

    task automatic wait_awaited(input string tag);
        int n = 0;
        while (!write_awaited && n < 40) begin
            tick();
            n++;
        end
        check(tag, write_awaited, 1'b1);
    endtask

    task automatic pix(input int x, input int y, input logic [8:0] c, input logic tr);
        write_active      = 1'b1;
        write_x_addr      = x;
        write_y_addr      = y;
        write_color_data  = c;
        write_transparent = tr;
        tick();
    endtask

    task automatic idle_bus();
        write_active      = 1'b0;
        write_transparent = 1'b0;
    endtask

    initial begin
        int cnt;
        resetN = 1'b0; frame = 1'b0;
        idle_bus();
        write_x_addr = 0; write_y_addr = 0; write_color_data = 0;
        tick(); tick();
        check("rst_busy", busy, 0);
        check("rst_we", fb_we, 0);
        check("rst_sel", write_source_sel, 0);
        check("rst_awaited", write_awaited, 0);
        check("rst_done", frame_done, 0);
        check("rst_flags", {frame_overrun, source_timeout}, 0);
        resetN = 1'b1;
        tick();

        // 1: three in-range pixels from source 0
        pulse_frame();
        check("t1_busy", busy, 1);
        check("t1_grant_sel", write_source_sel, 0);
        wait_awaited("t1_await0");
        pix(10, 20, 9'h1a5, 1'b0);
        check("t1_we0", fb_we, 1);
        check("t1_addr0", fb_addr, 12810);
        check("t1_data0", fb_data, 9'h1a5);
        pix(639, 479, 9'h0f0, 1'b0);
        check("t1_we1", fb_we, 1);
        check("t1_addr1", fb_addr, 307199);
        pix(0, 0, 9'h003, 1'b0);
        check("t1_we2", fb_we, 1);
        check("t1_addr2", fb_addr, 0);
        check("t1_data2", fb_data, 9'h003);
        idle_bus();
        tick();
        check("t1_end_we", fb_we, 0);
        wait_awaited("t1_await1");
        check("t1_sel1", write_source_sel, 1);

        // 2: rejected pixels on source 1, pass still completes
        pix(-1, 5, 9'h1ff, 1'b0);
        check("t2_xneg", fb_we, 0);
        pix(640, 5, 9'h1ff, 1'b0);
        check("t2_xbig", fb_we, 0);
        pix(5, 480, 9'h1ff, 1'b0);
        check("t2_ybig", fb_we, 0);
        pix(5, 5, 9'h1ff, 1'b1);
        check("t2_transp", fb_we, 0);
        idle_bus();
        tick();
        check("t2_next_we", fb_we, 0);
        tick();
        check("t2_done", frame_done, 1);
        check("t2_done_busy", busy, 0);
        check("t2_done_sel", write_source_sel, 0);
        tick();
        check("t2_done_pulse", frame_done, 0);
        check("t2_no_flags", {frame_overrun, source_timeout}, 0);

        // 3: source 1 times out
        pulse_frame();
        wait_awaited("t3_await0");
        pix(1, 0, 9'h011, 1'b0);
        check("t3_addr", fb_addr, 1);
        idle_bus();
        tick();
        wait_awaited("t3_await1");
        cnt = 0;
        while (write_awaited && cnt < 100) begin
            cnt++;
            tick();
        end
        check("t3_await_len", cnt, 16);
        check("t3_timeout", source_timeout, 1);
        tick();
        check("t3_done", frame_done, 1);
        check("t3_busy", busy, 0);

        // 4: frame during stream sets overrun, only one pass runs
        tick();
        pulse_frame();
        wait_awaited("t4_await0");
        pix(2, 2, 9'h022, 1'b0);
        frame = 1'b1;
        pix(3, 2, 9'h022, 1'b0);
        frame = 1'b0;
        check("t4_overrun", frame_overrun, 1);
        idle_bus();
        cnt = 0;
        for (int i = 0; i < 80; i++) begin
            tick();
            if (frame_done) cnt++;
        end
        check("t4_done_count", cnt, 1);
        check("t4_busy_after", busy, 0);

        // 5: reset mid-stream flushes the pipeline
        pulse_frame();
        wait_awaited("t5_await0");
        pix(2, 0, 9'h055, 1'b0);
        check("t5_we_before", fb_we, 1);
        resetN = 1'b0;
        pix(3, 0, 9'h055, 1'b0);
        check("t5_we_flush", fb_we, 0);
        check("t5_busy", busy, 0);
        check("t5_sel", write_source_sel, 0);
        check("t5_flags", {frame_overrun, source_timeout}, 0);
        resetN = 1'b1;
        idle_bus();
        tick();
        check("t5_idle_we", fb_we, 0);
        pulse_frame();
        wait_awaited("t5_await_new");
        check("t5_new_sel", write_source_sel, 0);
        pix(7, 1, 9'h0aa, 1'b0);
        check("t5_new_addr", fb_addr, 647);
        check("t5_new_data", fb_data, 9'h0aa);
        idle_bus();
        tick();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/draw_write_arbiter.md
Name: draw_write_arbiter

Overview:
- Responder end of the shared draw-source write bus.
- Once per frame it grants each draw source in turn by driving write_source_sel and asserting write_awaited.
- It samples the source's pixel stream (write_active, colour, x/y, transparent) and converts accepted pixels into framebuffer write-port transactions.
- Sits between all draw sources (starfield, sprites, HUD) and the framebuffer RAM.

Parameters:
- SOURCE_COUNT, 4, number of draw sources; granted in ascending ID order 0..SOURCE_COUNT-1.
- SEL_W, 2, width of write_source_sel; must satisfy 2**SEL_W >= SOURCE_COUNT (minimum 1).
- COLOR_DEPTH, 9, pixel colour width.
- FB_WIDTH, 640, framebuffer width in pixels.
- FB_HEIGHT, 480, framebuffer height in pixels.
- FB_ADDR_W, 19, framebuffer address width; clog2(FB_WIDTH*FB_HEIGHT).
- WAIT_TIMEOUT, 1024, cycles to wait for a granted source to raise write_active before skipping it.
- BG_COLOR, 9'b000000000, clear colour; used only with the optional feature.

Ports:
- clk  in  1  system clock.
- resetN  in  1  synchronous active-low reset.
- frame  in  1  single-cycle pulse at start of frame; starts a draw pass.
- write_source_sel  out  SEL_W  ID of the currently granted source.
- write_awaited  out  1  high while the arbiter waits for the granted source to start streaming.
- write_active  in  1  granted source is presenting a pixel this cycle.
- write_color_data  in  COLOR_DEPTH  pixel colour.
- write_transparent  in  1  pixel is not to be written.
- write_x_addr  in  32  signed pixel x.
- write_y_addr  in  32  signed pixel y.
- fb_we  out  1  framebuffer write strobe.
- fb_addr  out  FB_ADDR_W  framebuffer address, y*FB_WIDTH+x.
- fb_data  out  COLOR_DEPTH  framebuffer write data.
- busy  out  1  draw pass in progress.
- frame_done  out  1  single-cycle pulse when a pass completes.
- frame_overrun  out  1  sticky; set when frame arrives while busy.
- source_timeout  out  1  sticky; set when any source is skipped on timeout.

Behaviour:
- Reset values: all outputs 0; write_source_sel=0; state IDLE; timeout counter 0.
- Reset mid-pass: aborts the pass; the write pipeline is flushed, with no fb_we on the cycle after reset.
- IDLE:
  - busy=0.
  - On frame: state GRANT, sel=0, busy=1.
- GRANT (1 cycle): sel stable; state WAIT; timeout counter cleared.
- WAIT:
  - write_awaited=1.
  - write_active=1 -> STREAM; the same-cycle pixel is processed as a STREAM pixel.
  - Counter reaching WAIT_TIMEOUT-1 -> set source_timeout, go NEXT.
- STREAM:
  - write_awaited=0.
  - Each cycle with write_active=1 is one pixel.
  - Accept the pixel iff !write_transparent, 0<=x<FB_WIDTH and 0<=y<FB_HEIGHT (signed compare; negative values rejected).
  - An accepted pixel produces fb_we=1 with fb_addr/fb_data on the next clock: fixed 1-cycle latency, registered.
  - Rejected pixels produce fb_we=0.
  - write_active=0 ends the source's stream -> NEXT.
  - No length limit; a zero-pixel stream is impossible because STREAM is entered only on write_active.
- NEXT (1 cycle):
  - sel < SOURCE_COUNT-1 -> sel+1, GRANT.
  - Otherwise -> DONE.
- DONE (1 cycle): frame_done=1, busy=0, sel=0 -> IDLE.
- frame while busy: ignored; frame_overrun set. frame coincident with DONE is also treated as overrun.
- Bus inputs are sampled only in WAIT/STREAM; values (including Z/X) are ignored in all other states.
- Address arithmetic:
  - Compute y*FB_WIDTH+x in FB_ADDR_W bits after the range check; never wraps.
  - FB_WIDTH is a constant, so the multiply may be shift-add.
- Back-to-back accepted pixels give one fb_we per cycle; no stalls.

Optional Feature:
- Macro: DRAW_WRITE_ARBITER_CLEAR_EN.
- Defined:
  - On frame, a CLEAR state runs before GRANT.
  - CLEAR writes BG_COLOR to addresses 0..FB_WIDTH*FB_HEIGHT-1, one per cycle, fb_we=1.
  - It then goes to GRANT. busy=1 throughout; write_awaited=0.
- Undefined: no CLEAR state; frame goes directly to GRANT and the framebuffer is never cleared by this block.

Test Plan:
1. SOURCE_COUNT=2; frame pulse; source 0 streams 3 pixels (10,20),(639,479),(0,0), none transparent -> fb_we on 3 consecutive cycles with fb_addr 12810, 307199, 0; then sel=1.
2. Streamed pixels x=-1, x=640, y=480, and transparent (5,5) -> no fb_we; the pass still completes with a frame_done pulse.
3. Source 1 never raises write_active, WAIT_TIMEOUT=16 -> awaited high exactly 16 cycles; source_timeout=1; frame_done pulses; busy=0.
4. frame pulse during source 0 STREAM -> frame_overrun=1; exactly one pass completes with one frame_done pulse.
5. resetN=0 for 1 cycle mid-STREAM -> next cycle fb_we=0, busy=0, sel=0; a later frame starts a clean pass from source 0.
6. With DRAW_WRITE_ARBITER_CLEAR_EN defined: frame -> 307200 consecutive fb_we cycles with BG_COLOR, addresses 0..307199, before write_awaited first rises.
